// File: rtl/vedic_mult_pipe.sv
// Pipelined NxN Vedic (Urdhva Tiryakbhyam) multiplier with valid/ready handshake.
// Optional signed operands are enabled with `define SIGNED_MODE_EN.

// 2x2 leaf cell: vertical and crosswise partial products of two 2-bit operands.
module vedic_cell2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_hi;
  logic cross_lo;
  logic carry1;
  logic top;

  assign cross_hi = a[1] & b[0];
  assign cross_lo = a[0] & b[1];
  assign carry1   = cross_hi & cross_lo;
  assign top      = a[1] & b[1];

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_hi ^ cross_lo;
  assign p[2] = top ^ carry1;
  assign p[3] = top & carry1;
endmodule

// Combinational W x W Vedic tree, split recursively into four W/2 products.
module vedic_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  generate
    if (W == 2) begin : g_leaf
      vedic_cell2 u_cell (.a(a), .b(b), .p(p));
    end else begin : g_split
      localparam int H = W / 2;

      logic [W-1:0] q_ll;
      logic [W-1:0] q_hl;
      logic [W-1:0] q_lh;
      logic [W-1:0] q_hh;

      vedic_core #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q_ll));
      vedic_core #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(q_hl));
      vedic_core #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(q_lh));
      vedic_core #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(q_hh));

      assign p = {q_hh, {W{1'b0}}}
               + {{H{1'b0}}, q_hl, {H{1'b0}}}
               + {{H{1'b0}}, q_lh, {H{1'b0}}}
               + {{W{1'b0}}, q_ll};
    end
  endgenerate
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef SIGNED_MODE_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);
  localparam int H = WIDTH / 2;

  logic                 adv;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;

  logic [WIDTH-1:0]     pp_ll;
  logic [WIDTH-1:0]     pp_hl;
  logic [WIDTH-1:0]     pp_lh;
  logic [WIDTH-1:0]     pp_hh;

  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_ll;
  logic [WIDTH-1:0]     s2_hl;
  logic [WIDTH-1:0]     s2_lh;
  logic [WIDTH-1:0]     s2_hh;

  logic [2*WIDTH-1:0]   sum;
  logic [2*WIDTH-1:0]   s3_next;
  logic                 s3_valid;
  logic [2*WIDTH-1:0]   s3_product;

  // The whole pipe freezes as one while the consumer refuses a valid product.
  assign adv      = ~(s3_valid & ~out_ready);
  assign in_ready = adv;

`ifdef SIGNED_MODE_EN
  logic in_neg;
  logic s1_neg;
  logic s2_neg;

  // Magnitude of the most negative value (e.g. -128) still fits as unsigned.
  always_comb begin
    a_mag  = in_a;
    b_mag  = in_b;
    in_neg = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    if (in_signed && in_a[WIDTH-1]) a_mag = -in_a;
    if (in_signed && in_b[WIDTH-1]) b_mag = -in_b;
  end
`else
  assign a_mag = in_a;
  assign b_mag = in_b;
`endif

  vedic_core #(.W(H)) u_pp_ll (.a(s1_a[H-1:0]),     .b(s1_b[H-1:0]),     .p(pp_ll));
  vedic_core #(.W(H)) u_pp_hl (.a(s1_a[WIDTH-1:H]), .b(s1_b[H-1:0]),     .p(pp_hl));
  vedic_core #(.W(H)) u_pp_lh (.a(s1_a[H-1:0]),     .b(s1_b[WIDTH-1:H]), .p(pp_lh));
  vedic_core #(.W(H)) u_pp_hh (.a(s1_a[WIDTH-1:H]), .b(s1_b[WIDTH-1:H]), .p(pp_hh));

  assign sum = {s2_hh, {WIDTH{1'b0}}}
             + {{H{1'b0}}, s2_hl, {H{1'b0}}}
             + {{H{1'b0}}, s2_lh, {H{1'b0}}}
             + {{WIDTH{1'b0}}, s2_ll};

  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    s3_next = sum;
`ifdef SIGNED_MODE_EN
    if (s2_neg) s3_next = -sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so out_product reads 0 rather than X after reset.
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_ll      <= '0;
      s2_hl      <= '0;
      s2_lh      <= '0;
      s2_hh      <= '0;
      s3_valid   <= 1'b0;
      s3_product <= '0;
`ifdef SIGNED_MODE_EN
      s1_neg     <= 1'b0;
      s2_neg     <= 1'b0;
`endif
    end else if (adv) begin
      // NOTE: non-blocking updates let every stage read its predecessor's old value.
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (in_valid) begin
        s1_a <= a_mag;
        s1_b <= b_mag;
`ifdef SIGNED_MODE_EN
        s1_neg <= in_neg;
`endif
      end
      if (s1_valid) begin
        s2_ll <= pp_ll;
        s2_hl <= pp_hl;
        s2_lh <= pp_lh;
        s2_hh <= pp_hh;
`ifdef SIGNED_MODE_EN
        s2_neg <= s1_neg;
`endif
      end
      if (s2_valid) s3_product <= s3_next;
    end
  end

  assign out_valid   = s3_valid;
  assign out_product = s3_product;
  assign busy        = s1_valid | s2_valid | s3_valid;
endmodule
